// File: rtl/approx_adder_error_monitor.sv
// approx_adder_error_monitor
// Exhaustively sweeps every input vector into an approximate adder,
// compares each registered sample against the exact sum and accumulates
// worst-case error, error count and the first worst-case vector.
// A run is judged against WCE_LIMIT once the sweep completes.
module approx_adder_error_monitor #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 3,
    parameter int WCE_LIMIT = 2,
    parameter int SETTLE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  pi_out,
    input  logic [OUT_W-1:0] po_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] max_err,
    output logic [IN_W:0]    err_count,
    output logic [IN_W-1:0]  worst_vec
);

    localparam int HALF  = IN_W / 2;
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [OUT_W-1:0] exact;
    logic [OUT_W-1:0] error;
    logic             settled;

    // Exact reference sum, absolute error of the adder, and end of settle window.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        exact   = OUT_W'(pi_out[HALF-1:0]) + OUT_W'(pi_out[IN_W-1:HALF]);
        error   = (exact >= po_in) ? (exact - po_in) : (po_in - exact);
        settled = (32'(settle_cnt) >= SETTLE);
    end

    // Sweep controller: walks pi_out through all vectors and folds in statistics.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pi_out     <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            max_err    <= '0;
            err_count  <= '0;
            worst_vec  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pi_out     <= '0;
                        settle_cnt <= '0;
                        max_err    <= '0;
                        err_count  <= '0;
                        worst_vec  <= '0;
                    end
                end
                RUN: begin
                    if (!settled) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end else begin
                        // Strict compare keeps the first vector that hit the maximum.
                        if (error > max_err) begin
                            max_err   <= error;
                            worst_vec <= pi_out;
                        end
                        if (error != '0) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (&pi_out) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pi_out     <= pi_out + 1'b1;
                            settle_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Verdict is only meaningful, and only asserted, once the sweep is complete.
    assign pass = done && (32'(max_err) <= WCE_LIMIT);

endmodule

// File: doc/approx_adder_error_monitor.md
# approx_adder_error_monitor

Self-checking harness stage for approximate adders: sweeps every input vector into the adder under check, samples its output, compares it against the exact sum, and accumulates error statistics. It drives the adder's `pi` inputs and consumes its `po` outputs. It is the synthesizable counterpart of an exhaustive testbench and reports worst-case error (WCE) pass/fail against a limit.

## Interface
- `IN_W`, 4: total adder input bits, must be even. Operand a = `pi_out[IN_W/2-1:0]`, operand b = `pi_out[IN_W-1:IN_W/2]`.
- `OUT_W`, 3: adder output bits. Must equal IN_W/2+1.
- `WCE_LIMIT`, 2: maximum allowed absolute error.
- `SETTLE`, 1: extra cycles each vector is held before sampling, ≥0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `pi_out`  out  IN_W  vector driven to the adder under check.
- `po_in`  in  OUT_W  adder result; combinational response to `pi_out`.
- `busy`  out  1  high while sweeping.
- `done`  out  1  high in DONE until the next accepted start.
- `pass`  out  1  valid when `done`=1: `max_err` ≤ WCE_LIMIT.
- `max_err`  out  OUT_W  largest |exact − po_in| seen in the run.
- `err_count`  out  IN_W+1  number of vectors with nonzero error.
- `worst_vec`  out  IN_W  first vector that reached `max_err`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with `start`=1: clear the statistics, set `pi_out`=0 and `settle_cnt`=0, then go to RUN.
- RUN, at each edge:
  - If `settle_cnt` < SETTLE: increment `settle_cnt`.
  - Otherwise: sample `po_in` and update the statistics.
  - If `pi_out` is all ones: go to DONE. Otherwise increment `pi_out` and reset `settle_cnt` to 0.
- Exact sum = a + b, zero-extended to OUT_W; it cannot overflow.
- Error = exact − po_in if exact ≥ po_in, else po_in − exact. The unsigned OUT_W result is exact.
- Statistics update:
  - If error > `max_err`: load `max_err` = error and `worst_vec` = `pi_out`. Ties do not update.
  - If error ≠ 0: increment `err_count`. Its maximum is 2^IN_W, which fits in IN_W+1 bits.
- `start` in RUN is ignored.
- In DONE, `pi_out` holds its last value (all ones) and the statistics hold.
- `pass` = `done` AND (`max_err` ≤ WCE_LIMIT). It is 0 whenever `done`=0.

## Timing
- Reset values: state IDLE, `pi_out`=0, `busy`=0, `done`=0, `pass`=0, `max_err`=0, `err_count`=0, `worst_vec`=0.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous). The run is abandoned, and no partial result is kept.
- Each vector is held for SETTLE+1 cycles. `po_in` is sampled on the last edge of that window.
- A full run takes 2^IN_W × (SETTLE+1) cycles, from the start-accept edge to the edge that enters DONE. Defaults: 32 cycles.
- `busy` is high from the edge after start-accept through the final sample edge. `done` rises on that same edge.
- `busy` and `done` are never high together.
- Restart from DONE: `done` drops and `busy` rises on the accept edge, and the statistics clear on that edge.

## Test plan
- Exact adder model (po = a+b), defaults: `done` rises 32 cycles after start; `max_err`=0, `err_count`=0, `worst_vec`=0000, `pass`=1.
- Adder model stuck at `po`=000: `max_err`=6, `worst_vec`=1111, `err_count`=15, `pass`=0.
- Exact adder except vector 0101 returns 100 (exact 010): `max_err`=2, `err_count`=1, `worst_vec`=0101, `pass`=1. Same setup but returning 101 instead: `max_err`=3, `pass`=0.
- Tie handling: errors of 1 injected at vectors 0011 and 1100 → `worst_vec`=0011, `max_err`=1, `err_count`=2.
- Control: pulse `start` repeatedly during RUN → run length unchanged at 32 cycles. Assert `rst_n`=0 at cycle 10 of a run → all outputs zero, IDLE. A later start runs a clean sweep. Start from DONE → statistics cleared, second run gives results identical to the first.
- SETTLE=3: each `pi_out` value is held for 4 cycles, and the run completes in 64 cycles.
